// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch controller: address width,
// parameter defaults, FSM state encoding and a word-alignment helper.
package pc_fetch_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP_DEF  = 32'd4;

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Clear the byte-offset bits so redirect targets are always word aligned
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction memory request/acknowledge bus between the fetch controller
// (master) and the instruction memory (slave).
interface pc_fetch_ctrl_if;
  import pc_fetch_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [ADDR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next fetch address: word-aligned redirect target when a redirect is
// taken, otherwise the sequential successor (wraps modulo 2^32).
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_STEP = PC_STEP_DEF
) (
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              sel_dir,
  input  logic [ADDR_W-1:0] direction,
  output logic [ADDR_W-1:0] next_pc
);

  // Redirect target or sequential increment
  always_comb begin
    next_pc = fetch_pc + PC_STEP;
    if (sel_dir) next_pc = word_align(direction);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller. Issues one memory request at a time,
// presents the returned word to decode, and follows branch redirects.
// A redirect that arrives while a request is outstanding is remembered and
// applied once the memory acknowledges; the returned data is then dropped.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              sel_dir,
  input  logic [ADDR_W-1:0] direction,
  input  logic              stall,
  pc_fetch_ctrl_if.master   bus,
  output logic [ADDR_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_pend;
  logic              halt_pend;
  logic              req;

  pc_next_sel #(
    .PC_STEP (PC_STEP)
  ) u_next_sel (
    .fetch_pc  (fetch_pc),
    .sel_dir   (sel_dir),
    .direction (direction),
    .next_pc   (next_pc)
  );

  // The request address is the registered fetch pointer, so it cannot move
  // while a request waits for its acknowledge.
  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;

  // Fetch FSM with registered outputs; halt has priority over redirect and start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      redir_tgt   <= RESET_PC;
      redir_pend  <= 1'b0;
      halt_pend   <= 1'b0;
      req         <= 1'b0;
      instr       <= '0;
      pc          <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (start) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC;
            req      <= 1'b1;
          end
        end

        ST_REQ: begin
          if (bus.imem_ack) begin
            if (halt || halt_pend) begin
              // Handshake is complete; drop the data and stop
              state      <= ST_HALTED;
              halted     <= 1'b1;
              req        <= 1'b0;
              redir_pend <= 1'b0;
            end else if (sel_dir) begin
              // Redirect arriving with the ack: refetch the new target at once
              fetch_pc   <= next_pc;
              redir_pend <= 1'b0;
            end else if (redir_pend) begin
              fetch_pc   <= redir_tgt;
              redir_pend <= 1'b0;
            end else begin
              state       <= ST_ISSUE;
              instr       <= bus.imem_data;
              pc          <= fetch_pc;
              instr_valid <= 1'b1;
              req         <= 1'b0;
            end
          end else if (halt) begin
            halt_pend <= 1'b1;
          end else if (sel_dir) begin
            // Latest redirect wins if several arrive before the ack
            redir_pend <= 1'b1;
            redir_tgt  <= next_pc;
          end
        end

        ST_ISSUE: begin
          if (halt) begin
            state       <= ST_HALTED;
            halted      <= 1'b1;
            instr_valid <= 1'b0;
          end else if (sel_dir || !stall) begin
            // A redirect discards the issued word even while decode stalls
            state       <= ST_REQ;
            fetch_pc    <= next_pc;
            req         <= 1'b1;
            instr_valid <= 1'b0;
          end
        end

        ST_HALTED: begin
          halted <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pc_fetch_ctrl;
  import pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        sel_dir = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] direction = '0;

  logic [31:0] instr, pc, instr_w, pc_w;
  logic        instr_valid, halted, instr_valid_w, halted_w;

  int n_chk = 0;
  int n_pass = 0;

  pc_fetch_ctrl_if bus ();
  pc_fetch_ctrl_if bus_w ();

  pc_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt        (halt),
    .sel_dir     (sel_dir),
    .direction   (direction),
    .stall       (stall),
    .bus         (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  pc_fetch_ctrl #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt        (halt),
    .sel_dir     (sel_dir),
    .direction   (direction),
    .stall       (stall),
    .bus         (bus_w),
    .instr       (instr_w),
    .instr_valid (instr_valid_w),
    .pc          (pc_w),
    .halted      (halted_w)
  );

  // Wrap-around instance: memory acknowledges every request immediately
  assign bus_w.imem_ack  = bus_w.imem_req;
  assign bus_w.imem_data = ~bus_w.imem_addr;

  always #5 clk = ~clk;

  typedef struct {
    logic        st, hl, sd;
    logic [31:0] dir;
    logic        sl, ak;
    logic [31:0] dat;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pcx, ins;
    logic        hlt;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic st, logic hl, logic sd, logic [31:0] dir, logic sl,
                              logic ak, logic [31:0] dat, logic req, logic [31:0] addr,
                              logic vld, logic [31:0] pcx, logic [31:0] ins, logic hlt);
    vec_t v;
    v.st = st; v.hl = hl; v.sd = sd; v.dir = dir; v.sl = sl; v.ak = ak; v.dat = dat;
    v.req = req; v.addr = addr; v.vld = vld; v.pcx = pcx; v.ins = ins; v.hlt = hlt;
    return v;
  endfunction

  function automatic logic [98:0] pack(logic r, logic [31:0] a, logic v, logic [31:0] p,
                                       logic [31:0] i, logic h);
    return {r, a, v, p, i, h};
  endfunction

  function automatic logic [98:0] obs();
    return {bus.imem_req, bus.imem_addr, instr_valid, pc, instr, halted};
  endfunction

  function automatic logic [98:0] obs_w();
    return {bus_w.imem_req, bus_w.imem_addr, instr_valid_w, pc_w, instr_w, halted_w};
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string nm, input logic [98:0] act, input logic [98:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (req,addr,vld,pc,instr,halted)", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    start = 0; halt = 0; sel_dir = 0; stall = 0; direction = '0;
    bus.imem_ack = 0; bus.imem_data = '0;
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  // Behavioural reference: fetch engine described as "running / request in
  // flight / word held for decode / halted" flags plus the address to fetch.
  logic        m_on, m_halt, m_busy, m_rv, m_hp, m_valid;
  logic [31:0] m_addr, m_ra, m_pc, m_instr;

  task automatic model_step();
    logic [31:0] tgt;
    tgt = {direction[31:2], 2'b00};
    if (!rst_n) begin
      m_on = 0; m_halt = 0; m_busy = 0; m_rv = 0; m_hp = 0; m_valid = 0;
      m_addr = 32'h0; m_ra = 32'h0; m_pc = 32'h0; m_instr = 32'h0;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (!m_on) begin
      if (halt) m_halt = 1;
      else if (start) begin m_on = 1; m_busy = 1; m_addr = 32'h0; end
    end else if (m_busy) begin
      if (bus.imem_ack) begin
        if (halt || m_hp) begin m_halt = 1; m_busy = 0; end
        else if (sel_dir) begin m_addr = tgt; m_rv = 0; end
        else if (m_rv) begin m_addr = m_ra; m_rv = 0; end
        else begin
          m_instr = bus.imem_data; m_pc = m_addr; m_valid = 1; m_busy = 0;
        end
      end else if (halt) m_hp = 1;
      else if (sel_dir) begin m_rv = 1; m_ra = tgt; end
    end else begin
      if (halt) begin m_halt = 1; m_valid = 0; end
      else if (sel_dir) begin m_addr = tgt; m_busy = 1; m_valid = 0; end
      else if (!stall) begin m_addr = m_addr + 32'd4; m_busy = 1; m_valid = 0; end
    end
  endtask

  initial begin
    int wait_cnt;
    int cur_delay;

    // Vector table: inputs applied before an edge, outputs expected after it
    tbl[0]  = mk(0,0,0,32'h0,  0,1,32'h0000_DEAD, 0,32'h0,  0,32'h0,  32'h0,        0);
    tbl[1]  = mk(1,0,0,32'h0,  0,0,32'h0,        1,32'h0,  0,32'h0,  32'h0,        0);
    tbl[2]  = mk(1,0,0,32'h0,  0,1,32'h1000_0000, 0,32'h0,  1,32'h0,  32'h1000_0000, 0);
    tbl[3]  = mk(0,0,0,32'h0,  0,0,32'h0,        1,32'h4,  0,32'h0,  32'h1000_0000, 0);
    tbl[4]  = mk(0,0,0,32'h0,  0,1,32'h1000_0004, 0,32'h4,  1,32'h4,  32'h1000_0004, 0);
    tbl[5]  = mk(0,0,0,32'h0,  1,0,32'h0,        0,32'h4,  1,32'h4,  32'h1000_0004, 0);
    tbl[6]  = mk(0,0,0,32'h0,  1,1,32'hBAD0_BAD0, 0,32'h4,  1,32'h4,  32'h1000_0004, 0);
    tbl[7]  = mk(0,0,0,32'h0,  0,0,32'h0,        1,32'h8,  0,32'h4,  32'h1000_0004, 0);
    tbl[8]  = mk(0,0,0,32'h0,  0,1,32'h1000_0008, 0,32'h8,  1,32'h8,  32'h1000_0008, 0);
    tbl[9]  = mk(0,0,1,32'h103,1,0,32'h0,        1,32'h100,0,32'h8,  32'h1000_0008, 0);
    tbl[10] = mk(0,0,1,32'h207,0,0,32'h0,        1,32'h100,0,32'h8,  32'h1000_0008, 0);
    tbl[11] = mk(0,0,1,32'h20B,0,0,32'h0,        1,32'h100,0,32'h8,  32'h1000_0008, 0);
    tbl[12] = mk(0,0,0,32'h0,  0,1,32'hBAD0_0100, 1,32'h208,0,32'h8,  32'h1000_0008, 0);
    tbl[13] = mk(0,0,1,32'h300,0,1,32'hBAD0_0208, 1,32'h300,0,32'h8,  32'h1000_0008, 0);
    tbl[14] = mk(0,0,0,32'h0,  0,1,32'h1000_0300, 0,32'h300,1,32'h300,32'h1000_0300, 0);
    tbl[15] = mk(0,1,1,32'h500,0,0,32'h0,        0,32'h300,0,32'h300,32'h1000_0300, 1);
    tbl[16] = mk(1,0,1,32'h500,0,1,32'h0,        0,32'h300,0,32'h300,32'h1000_0300, 1);

    reset_dut();
    check("reset_state", obs(), pack(0, 32'h0, 0, 32'h0, 32'h0, 0));
    check("reset_state_w", obs_w(), pack(0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0));

    for (int i = 0; i < 17; i++) begin
      start = tbl[i].st; halt = tbl[i].hl; sel_dir = tbl[i].sd; direction = tbl[i].dir;
      stall = tbl[i].sl; bus.imem_ack = tbl[i].ak; bus.imem_data = tbl[i].dat;
      step();
      check($sformatf("vec%0d", i), obs(),
            pack(tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pcx, tbl[i].ins, tbl[i].hlt));
    end

    // halt beats simultaneous start and redirect in IDLE
    reset_dut();
    start = 1; halt = 1; sel_dir = 1; direction = 32'h40;
    step();
    check("idle_halt_wins", obs(), pack(0, 32'h0, 0, 32'h0, 32'h0, 1));

    // Redirect while a slow request is outstanding
    reset_dut();
    start = 1;
    step();
    start = 0; bus.imem_ack = 1; bus.imem_data = mem_word(32'h0);
    step();
    bus.imem_ack = 0; sel_dir = 1; direction = 32'h10;
    step();
    check("redir_to_10", obs(), pack(1, 32'h10, 0, 32'h0, mem_word(32'h0), 0));
    direction = 32'h40;
    step();
    check("slow_c1", obs(), pack(1, 32'h10, 0, 32'h0, mem_word(32'h0), 0));
    sel_dir = 0;
    step();
    check("slow_c2", obs(), pack(1, 32'h10, 0, 32'h0, mem_word(32'h0), 0));
    step();
    check("slow_c3", obs(), pack(1, 32'h10, 0, 32'h0, mem_word(32'h0), 0));
    bus.imem_ack = 1; bus.imem_data = 32'hDEAD_BEEF;
    step();
    check("slow_ack_drop", obs(), pack(1, 32'h40, 0, 32'h0, mem_word(32'h0), 0));
    bus.imem_data = mem_word(32'h40);
    step();
    check("fetch_40", obs(), pack(0, 32'h40, 1, 32'h40, mem_word(32'h40), 0));

    // Five stalled cycles in ISSUE, then the sequential fetch
    bus.imem_ack = 0; stall = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall%0d", k), obs(), pack(0, 32'h40, 1, 32'h40, mem_word(32'h40), 0));
    end
    stall = 0;
    step();
    check("stall_release", obs(), pack(1, 32'h44, 0, 32'h40, mem_word(32'h40), 0));

    // halt during REQ: wait for the ack, drop its data, then halt
    halt = 1;
    step();
    check("halt_req_c1", obs(), pack(1, 32'h44, 0, 32'h40, mem_word(32'h40), 0));
    step();
    check("halt_req_c2", obs(), pack(1, 32'h44, 0, 32'h40, mem_word(32'h40), 0));
    bus.imem_ack = 1; bus.imem_data = mem_word(32'h44);
    step();
    check("halt_req_ack", obs(), pack(0, 32'h44, 0, 32'h40, mem_word(32'h40), 1));
    halt = 0; bus.imem_ack = 0;

    // Reset pulse in the middle of a request, then a stray ack in IDLE
    reset_dut();
    start = 1;
    step();
    check("req_before_rst", obs(), pack(1, 32'h0, 0, 32'h0, 32'h0, 0));
    start = 0;
    rst_n = 0;
    #1;
    check("rst_async", obs(), pack(0, 32'h0, 0, 32'h0, 32'h0, 0));
    step();
    rst_n = 1; bus.imem_ack = 1; bus.imem_data = 32'h1234_5678;
    step();
    check("idle_ack_ignored", obs(), pack(0, 32'h0, 0, 32'h0, 32'h0, 0));
    bus.imem_ack = 0;

    // Address wrap from 0xFFFF_FFFC to 0 on the second instance
    reset_dut();
    start = 1;
    step();
    check("wrap_req0", obs_w(), pack(1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0));
    step();
    check("wrap_iss0", obs_w(), pack(0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h3, 0));
    step();
    check("wrap_req1", obs_w(), pack(1, 32'h0, 0, 32'hFFFF_FFFC, 32'h3, 0));
    step();
    check("wrap_iss1", obs_w(), pack(0, 32'h0, 1, 32'h0, 32'hFFFF_FFFF, 0));
    start = 0;

    // Randomized episodes against the behavioural model
    for (int ep = 0; ep < 6; ep++) begin
      reset_dut();
      rst_n = 0;
      @(posedge clk);
      model_step();
      #1;
      rst_n = 1;
      wait_cnt = 0;
      cur_delay = $urandom_range(0, 3);
      for (int c = 0; c < 150; c++) begin
        rst_n     = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        start     = ($urandom_range(0, 3) == 0);
        halt      = ($urandom_range(0, 99) == 0);
        sel_dir   = ($urandom_range(0, 7) == 0);
        direction = $urandom;
        stall     = ($urandom_range(0, 2) == 0);
        if (bus.imem_req) begin
          if (wait_cnt >= cur_delay) begin
            bus.imem_ack  = 1;
            bus.imem_data = mem_word(bus.imem_addr);
            wait_cnt      = 0;
            cur_delay     = $urandom_range(0, 3);
          end else begin
            bus.imem_ack  = 0;
            bus.imem_data = $urandom;
            wait_cnt++;
          end
        end else begin
          bus.imem_ack  = ($urandom_range(0, 7) == 0);
          bus.imem_data = $urandom;
          wait_cnt      = 0;
        end
        @(posedge clk);
        model_step();
        #1;
        check($sformatf("rand_e%0d_c%0d", ep, c), obs(),
              pack(m_busy, m_addr, m_valid, m_pc, m_instr, m_halt));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetch after start.
REQ-002 Parameter PC_STEP, default 4: sequential address increment in bytes.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: level; leave IDLE and begin fetching at RESET_PC.
REQ-006 Port halt, input, 1: level; stop fetching and enter HALTED.
REQ-007 Port sel_dir, input, 1: one-cycle redirect strobe (branch/jump taken).
REQ-008 Port direction, input, 32: redirect target, valid when sel_dir=1.
REQ-009 Port stall, input, 1: decode not ready; hold the issued instruction.
REQ-010 Port imem_req, output, 1: instruction memory request.
REQ-011 Port imem_addr, output, 32: fetch address, word aligned.
REQ-012 Port imem_ack, input, 1: memory returns imem_data this cycle.
REQ-013 Port imem_data, input, 32: fetched instruction word.
REQ-014 Port instr, output, 32: instruction presented to decode.
REQ-015 Port instr_valid, output, 1: instr and pc are valid.
REQ-016 Port pc, output, 32: address of instr.
REQ-017 Port halted, output, 1: high in HALTED state.

Function
REQ-018 FSM states SHALL be IDLE, REQ, ISSUE, HALTED; encoding SHALL come from the package.
REQ-019 IDLE: imem_req=0. If start=1 and halt=0, go to REQ with fetch_pc=RESET_PC.
REQ-020 REQ: imem_req=1. imem_addr=fetch_pc SHALL stay stable until the imem_ack cycle.
REQ-021 REQ, imem_ack=1, no redirect pending or arriving: latch instr<=imem_data and pc<=fetch_pc, go to ISSUE; instr_valid=1 from the next cycle.
REQ-022 ISSUE, stall=0, sel_dir=0: fetch_pc<=fetch_pc+PC_STEP (mod 2^32, wraps 32'hFFFF_FFFC->0), go to REQ; instr_valid=0 next cycle.
REQ-023 ISSUE, stall=1: hold instr, pc, instr_valid=1 and state unchanged.
REQ-024 Next-address select SHALL be sel_dir ? {direction[31:2],2'b00} : fetch_pc+PC_STEP; direction[1:0] is ignored.
REQ-025 sel_dir in ISSUE (stall ignored): drop instr (instr_valid=0 next cycle), fetch_pc<=target, go to REQ.
REQ-026 sel_dir in REQ without ack: record redir_pend=1 and the target; keep imem_addr unchanged. On ack, discard data, fetch_pc<=recorded target, stay in REQ, clear redir_pend.
REQ-027 sel_dir coincident with imem_ack in REQ: discard data, refetch the new target on the next cycle.
REQ-028 A second sel_dir while redir_pend=1 SHALL overwrite the recorded target (last wins).
REQ-029 Fetch throughput SHALL be one instruction per 2 cycles minimum (REQ+ISSUE) with single-cycle ack.
REQ-030 halt in IDLE or ISSUE: go to HALTED next cycle, instr_valid=0.
REQ-031 halt in REQ: complete the handshake, discard the ack data, then enter HALTED.
REQ-032 halt SHALL win over simultaneous sel_dir and start. HALTED exits only via rst_n.
REQ-033 sel_dir in IDLE or HALTED SHALL be ignored.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state=IDLE, fetch_pc=RESET_PC, redir_pend=0, imem_req=0, imem_addr=RESET_PC, instr=0, pc=0, instr_valid=0, halted=0.
REQ-035 Reset asserted mid-handshake SHALL abandon the request. An ack arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-036 Shared package pc_fetch_pkg SHALL hold the state enum, RESET_PC and PC_STEP defaults, and the 32-bit address width constant.
REQ-037 The next-address adder/select SHALL be a sub-module pc_next_sel (combinational; inputs fetch_pc, sel_dir, direction; output next_pc).

Verification
REQ-038 Reset, start=1, ack every REQ cycle, stall=0 -> imem_addr 0,4,8,C on alternating cycles; instr_valid pulses with matching pc.
REQ-039 ISSUE with pc=8, sel_dir=1, direction=32'h0000_0103 -> instr dropped; next imem_addr=32'h0000_0100.
REQ-040 REQ at addr 0x10, ack delayed 3 cycles, sel_dir=1 (0x40) in cycle 1 -> imem_addr stays 0x10 until ack; data discarded; next fetch 0x40; no instr_valid for 0x10.
REQ-041 stall=1 for 5 cycles in ISSUE -> instr/pc/instr_valid constant; no imem_req; fetch of pc+4 follows the stall release.
REQ-042 RESET_PC=32'hFFFF_FFFC, start -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-043 halt in REQ with ack at +2 cycles -> halted=1 after ack, no instr_valid; rst_n pulse mid-REQ -> imem_req=0 immediately.
